tl_ul_mem_arbiter: RTL and testbench
====================================

Name: tl_ul_mem_arbiter

Overview:
- Two-host to one-device arbiter for the core's TileLink-UL-style A/D channels.
- Lets instruction fetch (host 0) and data load/store (host 1) share one memory device: one channel_a/channel_d pair on the device side instead of two.
- Round-robin grant, one outstanding transaction, registered A-phase, D response routed back to the granted host.

Parameters:
- AW, 12, address width.
- DW, 32, data width; mask width is DW/8.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- h0_a_valid_i / h1_a_valid_i  in  1  host A request valid.
- h0_a_ready_o / h1_a_ready_o  out  1  host A request accepted.
- h0_a_opcode_i / h1_a_opcode_i  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- h0_a_address_i / h1_a_address_i  in  AW  byte address.
- h0_a_data_i / h1_a_data_i  in  DW  write data.
- h0_a_size_i / h1_a_size_i  in  2  log2 bytes.
- h0_a_mask_i / h1_a_mask_i  in  DW/8  byte lanes.
- h0_d_valid_o / h1_d_valid_o  out  1  response valid to host.
- h0_d_ready_i / h1_d_ready_i  in  1  host accepts response.
- h0_d_opcode_o / h1_d_opcode_o  out  3  0=AccessAck, 1=AccessAckData.
- h0_d_size_o / h1_d_size_o  out  2  response size.
- h0_d_data_o / h1_d_data_o  out  DW  read data.
- dev_a_valid_o  out  1  request to device.
- dev_a_ready_i  in  1  device accepts request.
- dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o  out  3/AW/DW/2/DW/8  registered request fields.
- dev_d_valid_i  in  1  device response valid.
- dev_d_ready_o  out  1  arbiter accepts response.
- dev_d_opcode_i, dev_d_size_i, dev_d_data_i  in  3/2/DW  response fields.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE and all outputs go to 0.
  - rr_last is set to 1, so host 0 wins the first tie.
- States: IDLE, ISSUE, WAIT_D.
- IDLE:
  - Winner is the only valid host; if both are valid, the host != rr_last.
  - Winner's hX_a_ready_o=1 combinationally in the same cycle; the loser's ready is 0.
  - On accept (valid&ready): latch opcode/address/data/size/mask into the request register and store grant=winner. Next state ISSUE.
- ISSUE:
  - dev_a_valid_o=1 and dev_a_* driven from the request register, held stable until dev_a_ready_i=1.
  - Both hX_a_ready_o=0.
  - On dev_a_valid_o&dev_a_ready_i: next state WAIT_D and dev_a_valid_o drops the following cycle.
- WAIT_D:
  - Granted host gets hG_d_valid_o=dev_d_valid_i and dev_d_opcode/size/data passed through combinationally.
  - dev_d_ready_o=hG_d_ready_i.
  - Non-granted host sees d_valid=0 and d_data=0.
  - On dev_d_valid_i&dev_d_ready_o: rr_last<=grant, next state IDLE.
- Latency: host accept at cycle N, dev_a_valid_o at N+1. Response reaches the host in the same cycle the device presents it. Minimum turnaround before the next grant is 1 IDLE cycle.
- dev_d_ready_o=0 in IDLE and ISSUE; a spurious dev_d_valid_i there is ignored and no host sees it.
- Host A valid may drop without being accepted (no grant lock before accept). Once accepted, the request cannot be cancelled.
- Opcodes are not decoded or checked; fields are forwarded unchanged.
- Grant is fair: with both hosts continuously requesting, grants strictly alternate 0,1,0,1…
- Reset mid-transaction:
  - The in-flight request is abandoned and outputs return to 0 immediately.
  - After release the arbiter restarts in IDLE with rr_last=1.

Test Plan:
- Single Get: h0 Get addr 0x010 → h0_a_ready_o=1 in the same cycle; next cycle dev_a_valid_o=1, opcode 4, addr 0x010. Device then returns AccessAckData 0xDEADBEEF → h0_d_valid_o=1 with data 0xDEADBEEF, opcode 1, while h1_d_valid_o=0.
- Contention: h0 and h1 valid in the same cycle after reset → h0 granted first, h1 second. Both requesting continuously for 4 transactions → grant order 0,1,0,1.
- Device A backpressure: h1 PutFullData addr 0x020, data 0x12345678, mask 0xF; dev_a_ready_i=0 for 3 cycles → dev_a_* stable for 3 cycles, no host ready asserted. Transfer completes on cycle 4.
- Host D backpressure: WAIT_D, dev_d_valid_i=1, h1_d_ready_i=0 for 2 cycles → dev_d_ready_o=0 and state held. Completes when h1_d_ready_i=1.
- Spurious response: dev_d_valid_i=1 in IDLE → dev_d_ready_o=0, both host d_valid=0.
- Reset in WAIT_D: assert reset low → all outputs 0 without waiting for a clock edge. After release, h1 alone requesting → h1 granted and its transaction completes normally.

Source files
------------

// File: rtl/tl_ul_mem_arbiter.sv
// Two-host to one-device TileLink-UL A/D arbiter: round-robin grant, a single
// outstanding transaction, registered device A-phase, D response steered back to the granted host.
module tl_ul_mem_arbiter #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            h0_a_valid_i,
  output logic            h0_a_ready_o,
  input  logic [2:0]      h0_a_opcode_i,
  input  logic [AW-1:0]   h0_a_address_i,
  input  logic [DW-1:0]   h0_a_data_i,
  input  logic [1:0]      h0_a_size_i,
  input  logic [DW/8-1:0] h0_a_mask_i,
  output logic            h0_d_valid_o,
  input  logic            h0_d_ready_i,
  output logic [2:0]      h0_d_opcode_o,
  output logic [1:0]      h0_d_size_o,
  output logic [DW-1:0]   h0_d_data_o,

  input  logic            h1_a_valid_i,
  output logic            h1_a_ready_o,
  input  logic [2:0]      h1_a_opcode_i,
  input  logic [AW-1:0]   h1_a_address_i,
  input  logic [DW-1:0]   h1_a_data_i,
  input  logic [1:0]      h1_a_size_i,
  input  logic [DW/8-1:0] h1_a_mask_i,
  output logic            h1_d_valid_o,
  input  logic            h1_d_ready_i,
  output logic [2:0]      h1_d_opcode_o,
  output logic [1:0]      h1_d_size_o,
  output logic [DW-1:0]   h1_d_data_o,

  output logic            dev_a_valid_o,
  input  logic            dev_a_ready_i,
  output logic [2:0]      dev_a_opcode_o,
  output logic [AW-1:0]   dev_a_address_o,
  output logic [DW-1:0]   dev_a_data_o,
  output logic [1:0]      dev_a_size_o,
  output logic [DW/8-1:0] dev_a_mask_o,

  input  logic            dev_d_valid_i,
  output logic            dev_d_ready_o,
  input  logic [2:0]      dev_d_opcode_i,
  input  logic [1:0]      dev_d_size_i,
  input  logic [DW-1:0]   dev_d_data_i
);

  localparam int unsigned MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic [1:0]    size;
    logic [MW-1:0] mask;
  } req_t;

  state_e state_q;
  logic   grant_q;
  logic   rr_last_q;
  logic   dev_a_valid_q;
  req_t   req_q;

  req_t   h0_req;
  req_t   h1_req;
  logic   in_idle;
  logic   in_wait;
  logic   winner;
  logic   accept;
  logic   h0_sel;
  logic   h1_sel;
  logic   d_done;

  assign h0_req = {h0_a_opcode_i, h0_a_address_i, h0_a_data_i, h0_a_size_i, h0_a_mask_i};
  assign h1_req = {h1_a_opcode_i, h1_a_address_i, h1_a_data_i, h1_a_size_i, h1_a_mask_i};

  // Every combinational output is qualified by reset so the ports read 0 the
  // moment reset is asserted, not just after the state register settles.
  assign in_idle = reset & (state_q == IDLE);
  assign in_wait = reset & (state_q == WAIT_D);

  // Sole requester wins; on a tie the host that was not served last wins.
  assign winner = (h0_a_valid_i & h1_a_valid_i) ? ~rr_last_q : h1_a_valid_i;

  assign h0_a_ready_o = in_idle & h0_a_valid_i & ~winner;
  assign h1_a_ready_o = in_idle & h1_a_valid_i &  winner;
  assign accept       = h0_a_ready_o | h1_a_ready_o;

  // D channel is a pure pass-through to the granted host while waiting.
  assign h0_sel = in_wait & ~grant_q;
  assign h1_sel = in_wait &  grant_q;

  assign h0_d_valid_o  = h0_sel & dev_d_valid_i;
  assign h0_d_opcode_o = h0_sel ? dev_d_opcode_i : 3'd0;
  assign h0_d_size_o   = h0_sel ? dev_d_size_i   : 2'd0;
  assign h0_d_data_o   = h0_sel ? dev_d_data_i   : DW'(0);

  assign h1_d_valid_o  = h1_sel & dev_d_valid_i;
  assign h1_d_opcode_o = h1_sel ? dev_d_opcode_i : 3'd0;
  assign h1_d_size_o   = h1_sel ? dev_d_size_i   : 2'd0;
  assign h1_d_data_o   = h1_sel ? dev_d_data_i   : DW'(0);

  assign dev_d_ready_o = (h0_sel & h0_d_ready_i) | (h1_sel & h1_d_ready_i);
  assign d_done        = dev_d_valid_i & dev_d_ready_o;

  assign dev_a_valid_o   = dev_a_valid_q;
  assign dev_a_opcode_o  = req_q.opcode;
  assign dev_a_address_o = req_q.address;
  assign dev_a_data_o    = req_q.data;
  assign dev_a_size_o    = req_q.size;
  assign dev_a_mask_o    = req_q.mask;

  // Transaction sequencer: capture request, present it to the device, await response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      rr_last_q     <= 1'b1;
      dev_a_valid_q <= 1'b0;
      req_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q         <= winner ? h1_req : h0_req;
            grant_q       <= winner;
            dev_a_valid_q <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (dev_a_ready_i) begin
            dev_a_valid_q <= 1'b0;
            state_q       <= WAIT_D;
          end
        end
        WAIT_D: begin
          if (d_done) begin
            rr_last_q <= grant_q;
            state_q   <= IDLE;
          end
        end
        default: begin
          dev_a_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_ul_mem_arbiter.sv
// Self-checking bench for tl_ul_mem_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_tl_ul_mem_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = DW / 8;
  localparam int unsigned RW  = 3 + AW + DW + 2 + MW;
  localparam int unsigned DRW = 1 + 3 + 2 + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          h0_a_valid_i, h1_a_valid_i;
  logic          h0_a_ready_o, h1_a_ready_o;
  logic [2:0]    h0_a_opcode_i, h1_a_opcode_i;
  logic [AW-1:0] h0_a_address_i, h1_a_address_i;
  logic [DW-1:0] h0_a_data_i, h1_a_data_i;
  logic [1:0]    h0_a_size_i, h1_a_size_i;
  logic [MW-1:0] h0_a_mask_i, h1_a_mask_i;
  logic          h0_d_valid_o, h1_d_valid_o;
  logic          h0_d_ready_i, h1_d_ready_i;
  logic [2:0]    h0_d_opcode_o, h1_d_opcode_o;
  logic [1:0]    h0_d_size_o, h1_d_size_o;
  logic [DW-1:0] h0_d_data_o, h1_d_data_o;
  logic          dev_a_valid_o, dev_a_ready_i;
  logic [2:0]    dev_a_opcode_o;
  logic [AW-1:0] dev_a_address_o;
  logic [DW-1:0] dev_a_data_o;
  logic [1:0]    dev_a_size_o;
  logic [MW-1:0] dev_a_mask_o;
  logic          dev_d_valid_i, dev_d_ready_o;
  logic [2:0]    dev_d_opcode_i;
  logic [1:0]    dev_d_size_i;
  logic [DW-1:0] dev_d_data_i;

  int errors = 0;
  int checks = 0;
  int rr_m   = 1;

  tl_ul_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .h0_a_valid_i(h0_a_valid_i), .h0_a_ready_o(h0_a_ready_o), .h0_a_opcode_i(h0_a_opcode_i),
    .h0_a_address_i(h0_a_address_i), .h0_a_data_i(h0_a_data_i), .h0_a_size_i(h0_a_size_i),
    .h0_a_mask_i(h0_a_mask_i), .h0_d_valid_o(h0_d_valid_o), .h0_d_ready_i(h0_d_ready_i),
    .h0_d_opcode_o(h0_d_opcode_o), .h0_d_size_o(h0_d_size_o), .h0_d_data_o(h0_d_data_o),
    .h1_a_valid_i(h1_a_valid_i), .h1_a_ready_o(h1_a_ready_o), .h1_a_opcode_i(h1_a_opcode_i),
    .h1_a_address_i(h1_a_address_i), .h1_a_data_i(h1_a_data_i), .h1_a_size_i(h1_a_size_i),
    .h1_a_mask_i(h1_a_mask_i), .h1_d_valid_o(h1_d_valid_o), .h1_d_ready_i(h1_d_ready_i),
    .h1_d_opcode_o(h1_d_opcode_o), .h1_d_size_o(h1_d_size_o), .h1_d_data_o(h1_d_data_o),
    .dev_a_valid_o(dev_a_valid_o), .dev_a_ready_i(dev_a_ready_i), .dev_a_opcode_o(dev_a_opcode_o),
    .dev_a_address_o(dev_a_address_o), .dev_a_data_o(dev_a_data_o), .dev_a_size_o(dev_a_size_o),
    .dev_a_mask_o(dev_a_mask_o), .dev_d_valid_i(dev_d_valid_i), .dev_d_ready_o(dev_d_ready_o),
    .dev_d_opcode_i(dev_d_opcode_i), .dev_d_size_i(dev_d_size_i), .dev_d_data_i(dev_d_data_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    h0_a_valid_i = 1'b0; h0_a_opcode_i = 3'd0; h0_a_address_i = '0; h0_a_data_i = '0;
    h0_a_size_i = 2'd0; h0_a_mask_i = '0; h0_d_ready_i = 1'b0;
    h1_a_valid_i = 1'b0; h1_a_opcode_i = 3'd0; h1_a_address_i = '0; h1_a_data_i = '0;
    h1_a_size_i = 2'd0; h1_a_mask_i = '0; h1_d_ready_i = 1'b0;
    dev_a_ready_i = 1'b0; dev_d_valid_i = 1'b0; dev_d_opcode_i = 3'd0;
    dev_d_size_i = 2'd0; dev_d_data_i = '0;
  endtask

  task automatic set_host(input int h, input logic v, input logic [2:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] sz, input logic [MW-1:0] m);
    if (h == 0) begin
      h0_a_valid_i = v; h0_a_opcode_i = op; h0_a_address_i = a;
      h0_a_data_i = d; h0_a_size_i = sz; h0_a_mask_i = m;
    end else begin
      h1_a_valid_i = v; h1_a_opcode_i = op; h1_a_address_i = a;
      h1_a_data_i = d; h1_a_size_i = sz; h1_a_mask_i = m;
    end
  endtask

  function automatic logic [2:0] pick_op(input int unsigned k);
    case (k)
      0:       return 3'd0;
      1:       return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    h0_a_valid_i = 1'b1; h1_a_valid_i = 1'b1; dev_d_valid_i = 1'b1;
    h0_d_ready_i = 1'b1; h1_d_ready_i = 1'b1; dev_d_data_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({h0_a_ready_o, h1_a_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o, dev_d_ready_o} !== 6'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {h0_a_ready_o, h1_a_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o, dev_d_ready_o});
    end
    checks++;
    if ({dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o} !== RW'(0)) begin
      errors++;
      $display("FAIL reset_dev_a got=%h exp=0",
               {dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o});
    end
    checks++;
    if ({h0_d_data_o, h1_d_data_o} !== 64'd0) begin
      errors++;
      $display("FAIL reset_d_data got=%h exp=0", {h0_d_data_o, h1_d_data_o});
    end
    clear_inputs();
    #1 reset = 1'b1;
    rr_m = 1;
    step();
  endtask

  task automatic test_single_get();
    set_host(0, 1'b1, 3'd4, 12'h010, 32'h0, 2'd2, 4'hF);
    @(negedge clk);
    checks++;
    if ({h0_a_ready_o, h1_a_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL get_a_ready got=%b exp=10", {h0_a_ready_o, h1_a_ready_o});
    end
    step();
    h0_a_valid_i = 1'b0; dev_a_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({dev_a_valid_o, dev_a_opcode_o, dev_a_address_o} !== {1'b1, 3'd4, 12'h010}) begin
      errors++;
      $display("FAIL get_dev_a got=%h exp=%h", {dev_a_valid_o, dev_a_opcode_o, dev_a_address_o},
               {1'b1, 3'd4, 12'h010});
    end
    step();
    dev_a_ready_i = 1'b0; dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1;
    dev_d_size_i = 2'd2; dev_d_data_i = 32'hDEAD_BEEF; h0_d_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({h0_d_valid_o, h0_d_opcode_o, h0_d_data_o} !== {1'b1, 3'd1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL get_d_h0 got=%h exp=%h", {h0_d_valid_o, h0_d_opcode_o, h0_d_data_o},
               {1'b1, 3'd1, 32'hDEAD_BEEF});
    end
    checks++;
    if ({h1_d_valid_o, h1_d_data_o} !== 33'd0) begin
      errors++;
      $display("FAIL get_d_h1 got=%h exp=0", {h1_d_valid_o, h1_d_data_o});
    end
    checks++;
    if ({dev_d_ready_o, dev_a_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL get_d_ready got=%b exp=10", {dev_d_ready_o, dev_a_valid_o});
    end
    step();
    clear_inputs();
    rr_m = 0;
  endtask

  task automatic test_contention();
    int exp_seq [4];
    exp_seq = '{0, 1, 0, 1};
    reset = 1'b0;
    #2 reset = 1'b1;
    rr_m = 1;
    set_host(0, 1'b1, 3'd4, 12'h100, 32'h0, 2'd2, 4'hF);
    set_host(1, 1'b1, 3'd4, 12'h200, 32'h0, 2'd2, 4'hF);
    dev_a_ready_i = 1'b1; dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1;
    dev_d_size_i = 2'd2; dev_d_data_i = 32'h0000_C0DE;
    h0_d_ready_i = 1'b1; h1_d_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({h1_a_ready_o, h0_a_ready_o} !== ((exp_seq[i] == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL cont_grant txn=%0d got={h1,h0}=%b exp_host=%0d", i,
                 {h1_a_ready_o, h0_a_ready_o}, exp_seq[i]);
      end
      step();
      @(negedge clk);
      checks++;
      if ({dev_a_valid_o, dev_a_address_o} !== {1'b1, (exp_seq[i] == 1) ? 12'h200 : 12'h100}) begin
        errors++;
        $display("FAIL cont_addr txn=%0d got=%h exp_host=%0d", i,
                 {dev_a_valid_o, dev_a_address_o}, exp_seq[i]);
      end
      step();
      @(negedge clk);
      checks++;
      if ({h1_d_valid_o, h0_d_valid_o} !== ((exp_seq[i] == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL cont_route txn=%0d got={h1,h0}=%b exp_host=%0d", i,
                 {h1_d_valid_o, h0_d_valid_o}, exp_seq[i]);
      end
      step();
    end
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_a_backpressure();
    set_host(1, 1'b1, 3'd0, 12'h020, 32'h1234_5678, 2'd2, 4'hF);
    @(negedge clk);
    checks++;
    if ({h1_a_ready_o, h0_a_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL bp_a_grant got=%b exp=10", {h1_a_ready_o, h0_a_ready_o});
    end
    step();
    set_host(0, 1'b1, 3'd4, 12'h0FF, 32'h0, 2'd0, 4'h1);
    set_host(1, 1'b1, 3'd1, 12'h0EE, 32'hFFFF_0000, 2'd1, 4'h3);
    for (int c = 0; c < 4; c++) begin
      dev_a_ready_i = (c == 3);
      @(negedge clk);
      checks++;
      if ({dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o}
          !== {1'b1, 3'd0, 12'h020, 32'h1234_5678, 2'd2, 4'hF}) begin
        errors++;
        $display("FAIL bp_a_hold cyc=%0d got=%h exp=%h", c,
                 {dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o},
                 {1'b1, 3'd0, 12'h020, 32'h1234_5678, 2'd2, 4'hF});
      end
      checks++;
      if ({h0_a_ready_o, h1_a_ready_o} !== 2'b00) begin
        errors++;
        $display("FAIL bp_a_noready cyc=%0d got=%b exp=00", c, {h0_a_ready_o, h1_a_ready_o});
      end
      step();
    end
    h0_a_valid_i = 1'b0; h1_a_valid_i = 1'b0; dev_a_ready_i = 1'b0;
    dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd0; dev_d_size_i = 2'd2; h1_d_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({dev_a_valid_o, h1_d_valid_o, h1_d_opcode_o, dev_d_ready_o} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL bp_a_done got=%b exp=010001", {dev_a_valid_o, h1_d_valid_o, h1_d_opcode_o, dev_d_ready_o});
    end
    step();
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_d_backpressure();
    set_host(1, 1'b1, 3'd4, 12'h030, 32'h0, 2'd2, 4'hF);
    step();
    h1_a_valid_i = 1'b0; dev_a_ready_i = 1'b1;
    step();
    dev_a_ready_i = 1'b0; dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1;
    dev_d_size_i = 2'd2; dev_d_data_i = 32'hCAFE_0001; h0_d_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      h1_d_ready_i = (c == 2);
      @(negedge clk);
      checks++;
      if (dev_d_ready_o !== (c == 2)) begin
        errors++;
        $display("FAIL bp_d_ready cyc=%0d got=%b exp=%b", c, dev_d_ready_o, (c == 2));
      end
      checks++;
      if ({h1_d_valid_o, h1_d_data_o, h0_d_valid_o} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin
        errors++;
        $display("FAIL bp_d_hold cyc=%0d got=%h exp=%h", c, {h1_d_valid_o, h1_d_data_o, h0_d_valid_o},
                 {1'b1, 32'hCAFE_0001, 1'b0});
      end
      step();
    end
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_spurious();
    dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1; dev_d_data_i = 32'h5A5A_5A5A;
    h0_d_ready_i = 1'b1; h1_d_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({dev_d_ready_o, h0_d_valid_o, h1_d_valid_o, h0_d_data_o, h1_d_data_o} !== 67'd0) begin
        errors++;
        $display("FAIL spur_idle cyc=%0d got=%h exp=0", c,
                 {dev_d_ready_o, h0_d_valid_o, h1_d_valid_o, h0_d_data_o, h1_d_data_o});
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    set_host(0, 1'b1, 3'd4, 12'h040, 32'h0, 2'd2, 4'hF);
    step();
    h0_a_valid_i = 1'b0; dev_a_ready_i = 1'b1;
    step();
    dev_a_ready_i = 1'b0; dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1;
    dev_d_data_i = 32'h55AA_55AA; h0_d_ready_i = 1'b0;
    h0_a_valid_i = 1'b1; h1_a_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({h0_d_valid_o, h0_d_data_o} !== {1'b1, 32'h55AA_55AA}) begin
      errors++;
      $display("FAIL rstmid_pre got=%h exp=%h", {h0_d_valid_o, h0_d_data_o}, {1'b1, 32'h55AA_55AA});
    end
    #1 reset = 1'b0;
    h0_d_ready_i = 1'b1;
    #1;
    checks++;
    if ({h0_a_ready_o, h1_a_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o, dev_d_ready_o} !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_ctrl got=%b exp=000000",
               {h0_a_ready_o, h1_a_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o, dev_d_ready_o});
    end
    checks++;
    if ({h0_d_data_o, h1_d_data_o, dev_a_address_o, dev_a_opcode_o} !== 79'd0) begin
      errors++;
      $display("FAIL rstmid_data got=%h exp=0", {h0_d_data_o, h1_d_data_o, dev_a_address_o, dev_a_opcode_o});
    end
    clear_inputs();
    #1 reset = 1'b1;
    rr_m = 1;
    step();
    set_host(1, 1'b1, 3'd4, 12'h050, 32'h0, 2'd2, 4'hF);
    @(negedge clk);
    checks++;
    if ({h1_a_ready_o, h0_a_ready_o} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_grant got=%b exp=10", {h1_a_ready_o, h0_a_ready_o});
    end
    step();
    h1_a_valid_i = 1'b0; dev_a_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({dev_a_valid_o, dev_a_address_o} !== {1'b1, 12'h050}) begin
      errors++;
      $display("FAIL rstmid_issue got=%h exp=%h", {dev_a_valid_o, dev_a_address_o}, {1'b1, 12'h050});
    end
    step();
    dev_a_ready_i = 1'b0; dev_d_valid_i = 1'b1; dev_d_opcode_i = 3'd1;
    dev_d_data_i = 32'h0BAD_F00D; h1_d_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({h1_d_valid_o, h1_d_data_o, dev_d_ready_o, h0_d_valid_o} !== {1'b1, 32'h0BAD_F00D, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rstmid_resp got=%h exp=%h", {h1_d_valid_o, h1_d_data_o, dev_d_ready_o, h0_d_valid_o},
               {1'b1, 32'h0BAD_F00D, 1'b1, 1'b0});
    end
    step();
    clear_inputs();
    rr_m = 1;
  endtask

  task automatic test_random(input int n);
    logic [2:0]    f_op   [2];
    logic [AW-1:0] f_addr [2];
    logic [DW-1:0] f_data [2];
    logic [1:0]    f_size [2];
    logic [MW-1:0] f_mask [2];
    for (int t = 0; t < n; t++) begin
      int            w;
      int            stall;
      int            dly;
      int            hs;
      logic [1:0]    v;
      logic          r;
      logic [2:0]    d_op;
      logic [1:0]    d_sz;
      logic [DW-1:0] d_dat;
      logic [RW-1:0] exp_a;
      logic [DRW-1:0] g_obs;
      logic [DRW-1:0] o_obs;
      for (int h = 0; h < 2; h++) begin
        f_op[h]   = pick_op($urandom_range(0, 2));
        f_addr[h] = AW'($urandom);
        f_data[h] = DW'($urandom);
        f_size[h] = 2'($urandom);
        f_mask[h] = MW'($urandom);
      end
      v = 2'($urandom_range(1, 3));
      w = (v == 2'b11) ? (1 - rr_m) : ((v == 2'b10) ? 1 : 0);
      exp_a = {f_op[w], f_addr[w], f_data[w], f_size[w], f_mask[w]};
      set_host(0, v[0], f_op[0], f_addr[0], f_data[0], f_size[0], f_mask[0]);
      set_host(1, v[1], f_op[1], f_addr[1], f_data[1], f_size[1], f_mask[1]);
      dev_d_valid_i = 1'($urandom); h0_d_ready_i = 1'($urandom); h1_d_ready_i = 1'($urandom);
      dev_a_ready_i = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({h1_a_ready_o, h0_a_ready_o} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rnd_grant txn=%0d valid=%b got={h1,h0}=%b exp_host=%0d", t, v,
                 {h1_a_ready_o, h0_a_ready_o}, w);
      end
      checks++;
      if ({dev_d_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o} !== 4'd0) begin
        errors++;
        $display("FAIL rnd_idle_quiet txn=%0d got=%b exp=0000", t,
                 {dev_d_ready_o, h0_d_valid_o, h1_d_valid_o, dev_a_valid_o});
      end
      step();
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        dev_a_ready_i = (s == stall);
        h0_a_valid_i = 1'($urandom); h1_a_valid_i = 1'($urandom);
        dev_d_valid_i = 1'($urandom);
        @(negedge clk);
        checks++;
        if ({dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o}
            !== {1'b1, exp_a}) begin
          errors++;
          $display("FAIL rnd_dev_a txn=%0d cyc=%0d got=%h exp=%h", t, s,
                   {dev_a_valid_o, dev_a_opcode_o, dev_a_address_o, dev_a_data_o, dev_a_size_o, dev_a_mask_o},
                   {1'b1, exp_a});
        end
        checks++;
        if ({h0_a_ready_o, h1_a_ready_o, dev_d_ready_o, h0_d_valid_o, h1_d_valid_o} !== 5'd0) begin
          errors++;
          $display("FAIL rnd_issue_quiet txn=%0d cyc=%0d got=%b exp=00000", t, s,
                   {h0_a_ready_o, h1_a_ready_o, dev_d_ready_o, h0_d_valid_o, h1_d_valid_o});
        end
        step();
      end
      dev_a_ready_i = 1'b0;
      dly = $urandom_range(0, 2);
      for (int s = 0; s < dly; s++) begin
        dev_d_valid_i = 1'b0;
        r = 1'($urandom);
        h0_d_ready_i = 1'($urandom); h1_d_ready_i = 1'($urandom);
        if (w == 1) h1_d_ready_i = r; else h0_d_ready_i = r;
        @(negedge clk);
        checks++;
        if ({dev_a_valid_o, h0_d_valid_o, h1_d_valid_o, h0_a_ready_o, h1_a_ready_o, dev_d_ready_o}
            !== {5'd0, r}) begin
          errors++;
          $display("FAIL rnd_wait_idle txn=%0d cyc=%0d got=%b exp=%b", t, s,
                   {dev_a_valid_o, h0_d_valid_o, h1_d_valid_o, h0_a_ready_o, h1_a_ready_o, dev_d_ready_o},
                   {5'd0, r});
        end
        step();
      end
      d_op = 3'($urandom_range(0, 1)); d_sz = 2'($urandom); d_dat = DW'($urandom);
      dev_d_opcode_i = d_op; dev_d_size_i = d_sz; dev_d_data_i = d_dat;
      hs = $urandom_range(0, 2);
      for (int s = 0; s <= hs; s++) begin
        dev_d_valid_i = 1'b1;
        h0_d_ready_i = 1'($urandom); h1_d_ready_i = 1'($urandom);
        if (w == 1) h1_d_ready_i = (s == hs); else h0_d_ready_i = (s == hs);
        @(negedge clk);
        g_obs = (w == 1) ? {h1_d_valid_o, h1_d_opcode_o, h1_d_size_o, h1_d_data_o}
                         : {h0_d_valid_o, h0_d_opcode_o, h0_d_size_o, h0_d_data_o};
        o_obs = (w == 1) ? {h0_d_valid_o, h0_d_opcode_o, h0_d_size_o, h0_d_data_o}
                         : {h1_d_valid_o, h1_d_opcode_o, h1_d_size_o, h1_d_data_o};
        checks++;
        if (g_obs !== {1'b1, d_op, d_sz, d_dat}) begin
          errors++;
          $display("FAIL rnd_d_route txn=%0d host=%0d got=%h exp=%h", t, w, g_obs, {1'b1, d_op, d_sz, d_dat});
        end
        checks++;
        if (o_obs !== DRW'(0)) begin
          errors++;
          $display("FAIL rnd_d_other txn=%0d host=%0d got=%h exp=0", t, 1 - w, o_obs);
        end
        checks++;
        if (dev_d_ready_o !== (s == hs)) begin
          errors++;
          $display("FAIL rnd_d_ready txn=%0d cyc=%0d got=%b exp=%b", t, s, dev_d_ready_o, (s == hs));
        end
        step();
      end
      rr_m = w;
      h0_a_valid_i = 1'b0; h1_a_valid_i = 1'b0; dev_d_valid_i = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_get();
    test_contention();
    test_a_backpressure();
    test_d_backpressure();
    test_spurious();
    test_reset_mid();
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
